// File: rtl/write_decoder_sb_if.sv
// rtl/write_decoder_sb_if.sv - write-back decode / scoreboard bus bundle
interface write_decoder_sb_if #(
  parameter int SEL_W = 5
);
  localparam int N = 1 << SEL_W;

  logic             ena;
  logic [SEL_W-1:0] sel;
  logic             issue_ena;
  logic [SEL_W-1:0] issue_sel;
  logic [SEL_W-1:0] rd_sel1;
  logic [SEL_W-1:0] rd_sel2;
  logic [N-1:0]     out;
  logic [N-1:0]     busy;
  logic             hazard1;
  logic             hazard2;
  logic             any_busy;

  modport master (
    output ena, sel, issue_ena, issue_sel, rd_sel1, rd_sel2,
    input  out, busy, hazard1, hazard2, any_busy
  );

  modport slave (
    input  ena, sel, issue_ena, issue_sel, rd_sel1, rd_sel2,
    output out, busy, hazard1, hazard2, any_busy
  );
endinterface

// File: rtl/write_decoder_sb.sv
// rtl/write_decoder_sb.sv - registered one-hot write decode with pending-write scoreboard
module write_decoder_sb #(
  parameter int SEL_W    = 5,
  parameter int ZERO_EN  = 1,
  parameter int ZERO_IDX = 31
) (
  input  logic                clk,
  input  logic                reset,
  write_decoder_sb_if.slave   bus
);
  localparam int N = 1 << SEL_W;

  function automatic logic is_zero(input logic [SEL_W-1:0] idx);
    return (ZERO_EN != 0) && (32'(idx) == ZERO_IDX);
  endfunction

  logic [N-1:0] out_q, out_d;
  logic [N-1:0] busy_q, busy_d;
  logic         any_busy_q, any_busy_d;
  logic         wb_hit, issue_hit;

  assign wb_hit    = bus.ena && !is_zero(bus.sel);
  assign issue_hit = bus.issue_ena && !is_zero(bus.issue_sel);

  always_comb begin
    out_d = '0;
    if (wb_hit) out_d[bus.sel] = 1'b1;
  end

  // Clear first, then set: a new writer issued alongside the retiring one stays outstanding.
  always_comb begin
    busy_d = busy_q;
    if (wb_hit)    busy_d[bus.sel]       = 1'b0;
    if (issue_hit) busy_d[bus.issue_sel] = 1'b1;
    any_busy_d = |busy_d;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_q      <= '0;
      busy_q     <= '0;
      any_busy_q <= 1'b0;
    end else begin
      out_q      <= out_d;
      busy_q     <= busy_d;
      any_busy_q <= any_busy_d;
    end
  end

  // A write retiring this cycle is bypassed by the register file, so it is not a hazard.
  assign bus.hazard1 = busy_q[bus.rd_sel1] && !(bus.ena && bus.sel == bus.rd_sel1)
                       && !is_zero(bus.rd_sel1);
  assign bus.hazard2 = busy_q[bus.rd_sel2] && !(bus.ena && bus.sel == bus.rd_sel2)
                       && !is_zero(bus.rd_sel2);

  assign bus.out      = out_q;
  assign bus.busy     = busy_q;
  assign bus.any_busy = any_busy_q;
endmodule

// File: tb/tb_write_decoder_sb.sv
// tb/tb_write_decoder_sb.sv - directed vector bench for write_decoder_sb
module tb_write_decoder_sb;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  write_decoder_sb_if #(.SEL_W(5)) bus1 ();
  write_decoder_sb_if #(.SEL_W(2)) bus2 ();

  write_decoder_sb #(.SEL_W(5), .ZERO_EN(1), .ZERO_IDX(31)) dut (
    .clk(clk), .reset(reset), .bus(bus1)
  );
  write_decoder_sb #(.SEL_W(2), .ZERO_EN(0), .ZERO_IDX(31)) dut_nz (
    .clk(clk), .reset(reset), .bus(bus2)
  );

  typedef struct {
    logic        rst;
    logic        ena;
    logic [4:0]  sel;
    logic        iss;
    logic [4:0]  isel;
    logic [4:0]  rd1;
    logic [4:0]  rd2;
    logic        chk_h;
    logic        h1;
    logic        h2;
    logic [31:0] out;
    logic [31:0] busy;
  } vec_t;

  vec_t vecs[$];
  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic add(input logic rst, input logic ena, input int sel, input logic iss,
                     input int isel, input int rd1, input int rd2, input logic chk_h,
                     input logic h1, input logic h2, input logic [31:0] out,
                     input logic [31:0] busy);
    vec_t v;
    v.rst = rst; v.ena = ena; v.sel = 5'(sel); v.iss = iss; v.isel = 5'(isel);
    v.rd1 = 5'(rd1); v.rd2 = 5'(rd2); v.chk_h = chk_h; v.h1 = h1; v.h2 = h2;
    v.out = out; v.busy = busy;
    vecs.push_back(v);
  endtask

  task automatic drive1(input logic rst, input logic ena, input logic [4:0] sel,
                        input logic iss, input logic [4:0] isel,
                        input logic [4:0] rd1, input logic [4:0] rd2);
    reset = rst; bus1.ena = ena; bus1.sel = sel; bus1.issue_ena = iss;
    bus1.issue_sel = isel; bus1.rd_sel1 = rd1; bus1.rd_sel2 = rd2;
  endtask

  initial begin
    drive1(1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 5'd0, 5'd0);
    bus2.ena = 1'b0; bus2.sel = '0; bus2.issue_ena = 1'b0; bus2.issue_sel = '0;
    bus2.rd_sel1 = '0; bus2.rd_sel2 = '0;

    //   rst ena sel iss isel rd1 rd2 chk h1 h2  out          busy
    add(1, 1, 3,  1, 3,  3,  3,  0, 0, 0, 32'h0,        32'h0);
    add(1, 1, 3,  1, 3,  3,  3,  1, 0, 0, 32'h0,        32'h0);
    add(0, 0, 0,  0, 0,  0,  0,  1, 0, 0, 32'h0,        32'h0);
    // issue X5, hold, bypass on write-back
    add(0, 0, 0,  1, 5,  5,  0,  1, 0, 0, 32'h0,        32'h20);
    add(0, 0, 0,  0, 0,  5,  0,  1, 1, 0, 32'h0,        32'h20);
    add(0, 0, 0,  0, 0,  5,  0,  1, 1, 0, 32'h0,        32'h20);
    add(0, 1, 5,  0, 0,  5,  0,  1, 0, 0, 32'h20,       32'h0);
    add(0, 0, 0,  0, 0,  5,  0,  1, 0, 0, 32'h0,        32'h0);
    // simultaneous set/clear same index, then different indices
    add(0, 0, 0,  1, 7,  7,  0,  1, 0, 0, 32'h0,        32'h80);
    add(0, 1, 7,  1, 7,  7,  0,  1, 0, 0, 32'h80,       32'h80);
    add(0, 1, 7,  1, 9,  9,  7,  1, 0, 0, 32'h80,       32'h200);
    add(0, 1, 9,  0, 0,  9,  0,  1, 0, 0, 32'h200,      32'h0);
    // zero register never decoded or tracked
    add(0, 0, 0,  1, 31, 0,  31, 1, 0, 0, 32'h0,        32'h0);
    add(0, 1, 31, 1, 31, 31, 31, 1, 0, 0, 32'h0,        32'h0);
    // clear of idle bit, hazard on port 2, WAW issue
    add(0, 0, 0,  1, 12, 0,  0,  1, 0, 0, 32'h0,        32'h1000);
    add(0, 1, 3,  0, 0,  3,  12, 1, 0, 1, 32'h8,        32'h1000);
    add(0, 0, 0,  1, 12, 0,  12, 1, 0, 1, 32'h0,        32'h1000);
    add(0, 1, 12, 0, 0,  0,  12, 1, 0, 0, 32'h1000,     32'h0);
    // reset mid-flight with bits 2,4,6 pending
    add(0, 0, 0,  1, 2,  0,  0,  1, 0, 0, 32'h0,        32'h4);
    add(0, 0, 0,  1, 4,  0,  0,  1, 0, 0, 32'h0,        32'h14);
    add(0, 0, 0,  1, 6,  0,  0,  1, 0, 0, 32'h0,        32'h54);
    add(1, 1, 2,  1, 8,  4,  6,  1, 1, 1, 32'h0,        32'h0);
    add(0, 0, 0,  0, 0,  4,  6,  1, 0, 0, 32'h0,        32'h0);

    for (int i = 0; i < vecs.size(); i++) begin
      drive1(vecs[i].rst, vecs[i].ena, vecs[i].sel, vecs[i].iss, vecs[i].isel,
             vecs[i].rd1, vecs[i].rd2);
      #1;
      if (vecs[i].chk_h) begin
        check($sformatf("v%0d_hazard1", i), {31'b0, bus1.hazard1}, {31'b0, vecs[i].h1});
        check($sformatf("v%0d_hazard2", i), {31'b0, bus1.hazard2}, {31'b0, vecs[i].h2});
      end
      @(posedge clk); #1;
      check($sformatf("v%0d_out", i), bus1.out, vecs[i].out);
      check($sformatf("v%0d_busy", i), bus1.busy, vecs[i].busy);
      check($sformatf("v%0d_any_busy", i), {31'b0, bus1.any_busy}, {31'b0, |vecs[i].busy});
    end

    // full decode sweep, back-to-back
    for (int s = 0; s < 32; s++) begin
      drive1(1'b0, 1'b1, 5'(s), 1'b0, 5'd0, 5'd0, 5'd0);
      @(posedge clk); #1;
      check($sformatf("sweep_out_%0d", s), bus1.out, (s == 31) ? 32'h0 : (32'h1 << s));
    end
    for (int s = 0; s < 32; s += 5) begin
      drive1(1'b0, 1'b0, 5'(s), 1'b0, 5'd0, 5'd0, 5'd0);
      @(posedge clk); #1;
      check($sformatf("idle_out_%0d", s), bus1.out, 32'h0);
    end

    // no zero register: index 3 of a 4-entry file is a normal register
    drive1(1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 5'd0, 5'd0);
    bus2.ena = 1'b1; bus2.sel = 2'd3; bus2.issue_ena = 1'b1; bus2.issue_sel = 2'd3;
    bus2.rd_sel1 = 2'd3;
    #1;
    check("nz_hazard_pre", {31'b0, bus2.hazard1}, 32'h0);
    @(posedge clk); #1;
    check("nz_out", {28'b0, bus2.out}, 32'h8);
    check("nz_busy", {28'b0, bus2.busy}, 32'h8);
    check("nz_any_busy", {31'b0, bus2.any_busy}, 32'h1);
    bus2.ena = 1'b0; bus2.issue_ena = 1'b0;
    #1;
    check("nz_hazard_set", {31'b0, bus2.hazard1}, 32'h1);
    bus2.ena = 1'b1;
    #1;
    check("nz_hazard_bypass", {31'b0, bus2.hazard1}, 32'h0);
    @(posedge clk); #1;
    check("nz_busy_clr", {28'b0, bus2.busy}, 32'h0);
    check("nz_out2", {28'b0, bus2.out}, 32'h8);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/write_decoder_sb.md
# write_decoder_sb

Parametrised, registered successor to the 1-to-4 enable demux. It sits at the register-file write port of the pipelined CPU. It decodes a write-back enable and address into a registered one-hot write-enable vector. It also keeps a pending-write scoreboard, one busy bit per register, set at issue and cleared at write-back. Two read-port hazard queries are answered from the scoreboard with a same-cycle write-back bypass, feeding the stall logic. The hard-wired zero register (X31) is never decoded and never marked busy.

## Interface
Parameters:
- SEL_W, 5, address width; N = 2**SEL_W outputs/busy bits
- ZERO_EN, 1, 1 = index ZERO_IDX is a hard-wired zero register
- ZERO_IDX, 31, zero-register index (ignored when ZERO_EN = 0)

Ports (reset is synchronous and active-high; single clock):
- clk  in  1  clock, all state updates on rising edge
- reset  in  1  synchronous active-high reset
- ena  in  1  write-back enable
- sel  in  SEL_W  write-back register index
- issue_ena  in  1  instruction with destination register issued this cycle
- issue_sel  in  SEL_W  destination register of issuing instruction
- rd_sel1  in  SEL_W  read-port 1 query index
- rd_sel2  in  SEL_W  read-port 2 query index
- out  out  N  registered one-hot write enables
- busy  out  N  scoreboard, registered
- hazard1  out  1  combinational: rd_sel1 has a pending write not retiring this cycle
- hazard2  out  1  same for rd_sel2
- any_busy  out  1  OR of busy, registered

## Operation
- "zero(i)" = ZERO_EN && i == ZERO_IDX.
- Decode: next out = (ena && !zero(sel)) ? (1 << sel) : 0. Exactly zero or one bit is set, never more.
- Scoreboard set: issue_ena && !zero(issue_sel) sets busy[issue_sel].
- Scoreboard clear: ena && !zero(sel) clears busy[sel].
- Set and clear of the same index in the same cycle: set wins, and the bit stays or becomes 1 (new writer outstanding).
- Set and clear of different indices in the same cycle: both apply.
- Clear of a bit that is already 0: no effect, no error.
- Set of a bit that is already 1 (WAW issue): bit stays 1. A single bit is tracked per register, and the first write-back clears it. The stall logic must not issue WAW; the block does not count writers.
- Hazard query k: hazardk = busy[rd_selk] && !(ena && sel == rd_selk) && !zero(rd_selk). Write-back data is bypassed by the register file in the same cycle, so a retiring write is not a hazard.
- A same-cycle issue does not affect hazard. Issue and read of the same instruction are not self-hazards.
- any_busy is registered alongside busy, so it equals |busy at all times.
- All decode is behavioural; no gate delays are modelled.

## Timing
- Reset value (cycle after a reset edge): out = 0, busy = 0, any_busy = 0. hazard1/hazard2 = 0 whenever busy = 0.
- reset dominates ena/issue_ena in the same cycle: nothing is set, decoded or cleared.
- Reset mid-operation drops all pending busy bits. The pipeline flush is the owner's responsibility.
- Decode latency is 1 cycle: ena/sel sampled at edge t appear on out from edge t until edge t+1.
- Scoreboard latency is 1 cycle: busy reflects issue/clear sampled at the previous edge.
- hazard1/hazard2 are purely combinational from busy, ena, sel and rd_sel*. There is no register stage.
- Back-to-back write-backs every cycle are supported. out changes every cycle with no idle gap required.

## Test plan
- Reset/idle: assert reset 2 cycles with ena = 1, sel = 3, issue_ena = 1 -> out = 0, busy = 0, any_busy = 0, hazard1 = hazard2 = 0.
- Full sweep: ena = 1, sel = 0..31 on successive cycles -> out = 1 << sel one cycle later for sel 0..30, out = 0 for sel 31. With ena = 0 on any sel, out = 0.
- Issue/write-back: issue X5 at cycle 0 -> busy[5] = 1 and any_busy = 1 at cycle 1. rd_sel1 = 5 gives hazard1 = 1. At cycle 3, ena = 1, sel = 5 -> hazard1 = 0 in that cycle (bypass), busy[5] = 0 and any_busy = 0 at cycle 4.
- Simultaneous set/clear: busy[7] = 1; same cycle issue_sel = 7, sel = 7, both enabled -> busy[7] remains 1. Then issue X9 with write-back X7 -> busy = {bit 9} only.
- Zero register: issue_sel = 31 and rd_sel2 = 31 -> busy[31] never 1, hazard2 = 0. With ZERO_EN = 0, SEL_W = 2 -> sel = 3 decodes to out = 4'b1000.
- Reset mid-flight: busy bits 2, 4, 6 set; reset for one cycle with ena = 1, sel = 2 -> busy = 0, out = 0 after the edge.
